// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit processor controller.
//   - opcode constants and ALU select encodings
//   - controller state enum
//   - instruction word field positions
package cpu_pkg;

  localparam logic [7:0] OPC_LOADI = 8'h00;
  localparam logic [7:0] OPC_MOV   = 8'h01;
  localparam logic [7:0] OPC_ADD   = 8'h02;
  localparam logic [7:0] OPC_SUB   = 8'h03;
  localparam logic [7:0] OPC_AND   = 8'h04;
  localparam logic [7:0] OPC_OR    = 8'h05;
  localparam logic [7:0] OPC_HALT  = 8'hFF;

  localparam logic [2:0] ALU_FWD = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  // Instruction word: [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2/imm
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 24;
  localparam int DST_LSB  = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;

endpackage

// File: rtl/cpu_decoder.sv
// cpu_decoder: purely combinational opcode decode.
// Ports:
//   opcode_i   8-bit opcode
//   alu_sel_o  ALU function (FWD/ADD/AND/OR)
//   sub_sel_o  negate operand 2
//   imm_sel_o  use immediate as operand 2
//   legal_o    opcode is a write-back instruction
//   is_halt_o  opcode is the halt opcode
module cpu_decoder
  import cpu_pkg::*;
#(
  parameter logic [7:0] HALT_OPC = OPC_HALT
) (
  input  logic [7:0] opcode_i,
  output logic [2:0] alu_sel_o,
  output logic       sub_sel_o,
  output logic       imm_sel_o,
  output logic       legal_o,
  output logic       is_halt_o
);

  always_comb begin
    alu_sel_o = ALU_FWD;
    sub_sel_o = 1'b0;
    imm_sel_o = 1'b0;
    legal_o   = 1'b1;
    case (opcode_i)
      OPC_LOADI: imm_sel_o = 1'b1;
      OPC_MOV:   alu_sel_o = ALU_FWD;
      OPC_ADD:   alu_sel_o = ALU_ADD;
      OPC_SUB: begin
        alu_sel_o = ALU_ADD;
        sub_sel_o = 1'b1;
      end
      OPC_AND:   alu_sel_o = ALU_AND;
      OPC_OR:    alu_sel_o = ALU_OR;
      default:   legal_o   = 1'b0;
    endcase
    // Halt wins even if HALT_OPC is overridden onto a normal opcode.
    is_halt_o = (opcode_i == HALT_OPC);
    if (is_halt_o) begin
      legal_o   = 1'b0;
      alu_sel_o = ALU_FWD;
      sub_sel_o = 1'b0;
      imm_sel_o = 1'b0;
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle fetch/decode/exec/writeback controller.
// Ports:
//   clk, reset        clock, async active-high reset
//   imem_addr         instruction address (= PC)
//   imem_rdata/valid  instruction word and its valid strobe
//   rf_in_addr, rf_out1_addr, rf_out2_addr, rf_wr_en  register file control
//   alu_sel, sub_sel, imm_sel, imm                   ALU control
//   halted, illegal   stop status (illegal is sticky)
//   retired           saturating count of completed write-backs
//
// state  | meaning
// FETCH  | wait for imem_valid, capture instruction into IR
// DECODE | decoded controls visible; pick EXEC or HALT
// EXEC   | controls stable while register reads and ALU settle
// WB     | rf_wr_en high for one cycle; PC and retired advance at exit
// HALT   | absorbing until reset
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned      PC_W     = 8,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [7:0]       HALT_OPC = OPC_HALT
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [2:0]      rf_in_addr,
  output logic [2:0]      rf_out1_addr,
  output logic [2:0]      rf_out2_addr,
  output logic            rf_wr_en,
  output logic [2:0]      alu_sel,
  output logic            sub_sel,
  output logic            imm_sel,
  output logic [7:0]      imm,
  output logic            halted,
  output logic            illegal,
  output logic [15:0]     retired
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q;
  logic [2:0]      alu_sel_q;
  logic            sub_sel_q, imm_sel_q;
  logic            rf_wr_en_q, halted_q, illegal_q;
  logic [15:0]     retired_q, retired_d;

  logic [7:0] dec_opc;
  logic [2:0] dec_alu_sel;
  logic       dec_sub_sel, dec_imm_sel, dec_legal, dec_is_halt;

  // In FETCH the decoder looks at the incoming word so the controls can be
  // registered alongside IR and be valid throughout DECODE; afterwards it
  // looks at IR to choose between EXEC and HALT.
  assign dec_opc = (state_q == S_FETCH) ? imem_rdata[OPC_MSB:OPC_LSB]
                                        : ir_q[OPC_MSB:OPC_LSB];

  cpu_decoder #(.HALT_OPC(HALT_OPC)) u_dec (
    .opcode_i  (dec_opc),
    .alu_sel_o (dec_alu_sel),
    .sub_sel_o (dec_sub_sel),
    .imm_sel_o (dec_imm_sel),
    .legal_o   (dec_legal),
    .is_halt_o (dec_is_halt)
  );

  assign pc_d      = pc_q + 1'b1;
  assign retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      alu_sel_q  <= ALU_FWD;
      sub_sel_q  <= 1'b0;
      imm_sel_q  <= 1'b0;
      rf_wr_en_q <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_valid) begin
            ir_q      <= imem_rdata;
            alu_sel_q <= dec_alu_sel;
            sub_sel_q <= dec_sub_sel;
            imm_sel_q <= dec_imm_sel;
            state_q   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_is_halt) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else if (!dec_legal) begin
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          rf_wr_en_q <= 1'b1;
          state_q    <= S_WB;
        end
        S_WB: begin
          rf_wr_en_q <= 1'b0;
          pc_q       <= pc_d;
          retired_q  <= retired_d;
          state_q    <= S_FETCH;
        end
        S_HALT: begin
          rf_wr_en_q <= 1'b0;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  // Opcode and upper address bits are not needed on the outputs.
  logic unused_ir;
  assign unused_ir = ^{ir_q[OPC_MSB:OPC_LSB], ir_q[DST_LSB+7:DST_LSB+3],
                       ir_q[SRC1_LSB+7:SRC1_LSB+3]};

  assign imem_addr    = pc_q;
  assign rf_in_addr   = ir_q[DST_LSB+2:DST_LSB];
  assign rf_out1_addr = ir_q[SRC1_LSB+2:SRC1_LSB];
  assign rf_out2_addr = ir_q[SRC2_LSB+2:SRC2_LSB];
  assign imm          = ir_q[SRC2_LSB+7:SRC2_LSB];
  assign rf_wr_en     = rf_wr_en_q;
  assign alu_sel      = alu_sel_q;
  assign sub_sel      = sub_sel_q;
  assign imm_sel      = imm_sel_q;
  assign halted       = halted_q;
  assign illegal      = illegal_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm. Two instances share stimulus: one with
// RESET_PC = 0, one with RESET_PC = 255 to observe PC wrap.
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;

  logic [7:0]  imem_addr, w_imem_addr;
  logic [2:0]  rf_in_addr, rf_out1_addr, rf_out2_addr;
  logic [2:0]  w_rf_in_addr, w_rf_out1_addr, w_rf_out2_addr;
  logic        rf_wr_en, w_rf_wr_en;
  logic [2:0]  alu_sel, w_alu_sel;
  logic        sub_sel, imm_sel, w_sub_sel, w_imm_sel;
  logic [7:0]  imm, w_imm;
  logic        halted, illegal, w_halted, w_illegal;
  logic [15:0] retired, w_retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_ctrl_fsm dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .rf_in_addr(rf_in_addr), .rf_out1_addr(rf_out1_addr),
    .rf_out2_addr(rf_out2_addr), .rf_wr_en(rf_wr_en), .alu_sel(alu_sel),
    .sub_sel(sub_sel), .imm_sel(imm_sel), .imm(imm), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  cpu_ctrl_fsm #(.RESET_PC(8'd255)) dut_w (
    .clk(clk), .reset(reset), .imem_addr(w_imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .rf_in_addr(w_rf_in_addr), .rf_out1_addr(w_rf_out1_addr),
    .rf_out2_addr(w_rf_out2_addr), .rf_wr_en(w_rf_wr_en), .alu_sel(w_alu_sel),
    .sub_sel(w_sub_sel), .imm_sel(w_imm_sel), .imm(w_imm), .halted(w_halted),
    .illegal(w_illegal), .retired(w_retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full instruction from FETCH: ends sampling in the following FETCH.
  task automatic run_instr(input logic [31:0] word);
    imem_rdata = word;
    imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_wr_en", 32'(rf_wr_en), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    chk("rst_retired", 32'(retired), 32'h0);
    chk("rst_ctrl", {imm, rf_in_addr, rf_out1_addr, rf_out2_addr, alu_sel, sub_sel, imm_sel},
        32'h0);
    chk("rst_w_addr", 32'(w_imem_addr), 32'hFF);
    reset = 1'b0;

    // loadi r3, 42
    imem_rdata = 32'h00_03_00_2A;
    imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    chk("ld_in_addr", 32'(rf_in_addr), 32'd3);
    chk("ld_imm_sel", 32'(imm_sel), 32'd1);
    chk("ld_imm", 32'(imm), 32'd42);
    chk("ld_alu_sel", 32'(alu_sel), 32'd0);
    chk("ld_dec_wr_en", 32'(rf_wr_en), 32'd0);
    step();
    chk("ld_exec_wr_en", 32'(rf_wr_en), 32'd0);
    step();
    chk("ld_wb_wr_en", 32'(rf_wr_en), 32'd1);
    chk("ld_wb_retired", 32'(retired), 32'd0);
    step();
    chk("ld_post_wr_en", 32'(rf_wr_en), 32'd0);
    chk("ld_pc", 32'(imem_addr), 32'd1);
    chk("ld_retired", 32'(retired), 32'd1);
    chk("wrap_pc", 32'(w_imem_addr), 32'd0);
    chk("wrap_retired", 32'(w_retired), 32'd1);

    // sub r5, r1, r2
    imem_rdata = 32'h03_05_01_02;
    imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    chk("sub_addrs", {rf_in_addr, rf_out1_addr, rf_out2_addr}, {23'd0, 3'd5, 3'd1, 3'd2});
    chk("sub_ctrl", {alu_sel, sub_sel, imm_sel}, {27'd0, 3'd1, 1'b1, 1'b0});
    step();
    chk("sub_exec_addrs", {rf_in_addr, rf_out1_addr, rf_out2_addr}, {23'd0, 3'd5, 3'd1, 3'd2});
    step();
    chk("sub_wb_wr_en", 32'(rf_wr_en), 32'd1);
    chk("sub_wb_addrs", {rf_in_addr, rf_out1_addr, rf_out2_addr}, {23'd0, 3'd5, 3'd1, 3'd2});
    chk("sub_wb_ctrl", {alu_sel, sub_sel, imm_sel}, {27'd0, 3'd1, 1'b1, 1'b0});
    step();
    chk("sub_pc", 32'(imem_addr), 32'd2);
    chk("sub_retired", 32'(retired), 32'd2);

    // Five cycles with no valid instruction
    imem_rdata = 32'h02_06_04_07;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_addr", 32'(imem_addr), 32'd2);
      chk("stall_wr_en", 32'(rf_wr_en), 32'd0);
      chk("stall_ctrl", {alu_sel, sub_sel}, {28'd0, 3'd1, 1'b1});
    end
    imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    chk("add_ctrl", {alu_sel, sub_sel, imm_sel}, {27'd0, 3'd1, 1'b0, 1'b0});
    chk("add_addrs", {rf_in_addr, rf_out1_addr, rf_out2_addr}, {23'd0, 3'd6, 3'd4, 3'd7});
    step();
    step();
    chk("add_3cyc_retired", 32'(retired), 32'd2);
    step();
    chk("add_4cyc_retired", 32'(retired), 32'd3);
    chk("add_pc", 32'(imem_addr), 32'd3);

    // and / or / mov / loadi with junk in the upper address bits
    run_instr(32'h04_F9_EA_DB);
    chk("and_addrs", {rf_in_addr, rf_out1_addr, rf_out2_addr}, {23'd0, 3'd1, 3'd2, 3'd3});
    chk("and_ctrl", {alu_sel, sub_sel, imm_sel}, {27'd0, 3'd2, 1'b0, 1'b0});
    run_instr(32'h05_00_00_00);
    chk("or_alu", 32'(alu_sel), 32'd3);
    run_instr(32'h01_02_03_04);
    chk("mov_ctrl", {alu_sel, sub_sel, imm_sel}, {27'd0, 3'd0, 1'b0, 1'b0});
    run_instr(32'h00_07_00_81);
    chk("ld2_imm", 32'(imm), 32'h81);
    chk("pre_halt_pc", 32'(imem_addr), 32'd7);
    chk("pre_halt_retired", 32'(retired), 32'd7);

    // HALT opcode at PC = 7
    imem_rdata = 32'hFF_01_02_03;
    imem_valid = 1'b1;
    step();
    chk("halt_dec_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_illegal", 32'(illegal), 32'd0);
      chk("halt_addr", 32'(imem_addr), 32'd7);
      chk("halt_wr_en", 32'(rf_wr_en), 32'd0);
      chk("halt_retired", 32'(retired), 32'd7);
    end
    imem_valid = 1'b0;

    // Undefined opcode
    do_reset();
    chk("rst2_halted", 32'(halted), 32'd0);
    imem_rdata = 32'h09_01_02_03;
    imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    step();
    chk("ill_halted", 32'(halted), 32'd1);
    chk("ill_illegal", 32'(illegal), 32'd1);
    chk("ill_addr", 32'(imem_addr), 32'd0);
    step();
    chk("ill_wr_en", 32'(rf_wr_en), 32'd0);
    chk("ill_retired", 32'(retired), 32'd0);

    // Wrap on the 255 instance, then reset in the middle of WB
    do_reset();
    chk("rst3_illegal", 32'(illegal), 32'd0);
    run_instr(32'h02_01_02_03);
    chk("wrap2_pc", 32'(w_imem_addr), 32'd0);
    chk("wrap2_retired", 32'(w_retired), 32'd1);
    imem_rdata = 32'h02_03_04_05;
    imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    step();
    step();
    chk("mid_wb_wr_en", 32'(rf_wr_en), 32'd1);
    chk("mid_wb_retired", 32'(retired), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_wr_en", 32'(rf_wr_en), 32'd0);
    chk("async_w_wr_en", 32'(w_rf_wr_en), 32'd0);
    chk("async_retired", 32'(retired), 32'd0);
    chk("async_pc", 32'(imem_addr), 32'd0);
    chk("async_w_pc", 32'(w_imem_addr), 32'hFF);
    step();
    chk("held_wr_en", 32'(rf_wr_en), 32'd0);
    chk("held_retired", 32'(retired), 32'd0);
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle fetch/decode/writeback controller for the 8-bit simple processor. It sits directly upstream of the 8x8 register file.
- Fetches 32-bit instructions from instruction memory.
- Drives the register file's read and write addresses plus its write strobe.
- Drives ALU select, immediate and subtract controls.
- Maintains the program counter and a retired-instruction count.

Parameters:
PC_W, 8, program counter / instruction address width
RESET_PC, 0, PC value loaded on reset
HALT_OPC, 8'hFF, opcode that stops the machine

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
imem_addr  out  PC_W  instruction address (= PC)
imem_rdata  in  32  instruction word: [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2/immediate
imem_valid  in  1  imem_rdata valid for imem_addr this cycle
rf_in_addr  out  3  register file write address (dest[2:0])
rf_out1_addr  out  3  register file read port 1 address (src1[2:0])
rf_out2_addr  out  3  register file read port 2 address (src2[2:0])
rf_wr_en  out  1  register file write strobe
alu_sel  out  3  0 = FWD, 1 = ADD, 2 = AND, 3 = OR
sub_sel  out  1  negate operand 2 (two's complement) before ALU
imm_sel  out  1  select immediate instead of OUT2 as operand 2
imm  out  8  immediate value (IR[7:0])
halted  out  1  machine stopped
illegal  out  1  sticky: stopped on an undefined opcode
retired  out  16  count of completed write-back instructions

Behaviour:
- Reset is asynchronous and active-high; one clock, clk. While reset is high, every output and all state take these values:
  - state = FETCH, PC = RESET_PC, IR = 0;
  - rf_wr_en = 0, halted = 0, illegal = 0, retired = 0;
  - all address, alu_sel, sub_sel and imm_sel outputs = 0.
- States are FETCH, DECODE, EXEC, WB and HALT.
- FETCH:
  - imem_addr = PC.
  - If imem_valid = 1 at the rising edge: IR <= imem_rdata, go to DECODE.
  - Otherwise stay in FETCH; there is no timeout.
- DECODE: register IR fields onto the rf_* addresses, imm and the control outputs.
  - Opcode mapping:
    - 0 loadi: FWD, imm_sel = 1
    - 1 mov: FWD, imm_sel = 0
    - 2 add: ADD
    - 3 sub: ADD, sub_sel = 1
    - 4 and: AND
    - 5 or: OR
  - Opcode == HALT_OPC: go to HALT, halted = 1 next cycle.
  - Any other opcode: go to HALT with halted = 1 and illegal = 1. The PC is not advanced in either HALT case.
  - Dest/src bits [7:3] are ignored. No error is raised for them.
- EXEC: controls held stable for one cycle so register file reads and the ALU settle. rf_wr_en stays 0.
- WB: rf_wr_en = 1 for exactly one full clk cycle, which covers the register file's negative-edge write. At the end of WB:
  - PC <= PC + 1, modulo 2^PC_W (max value wraps to 0);
  - retired <= retired + 1, saturating at 16'hFFFF;
  - go to FETCH.
- rf_wr_en and all rf_* addresses and controls hold stable from DECODE through WB. Addresses are never changed while rf_wr_en = 1.
- Latency per instruction: 4 cycles minimum (FETCH, DECODE, EXEC, WB) plus FETCH wait cycles.
- HALT:
  - Absorbing state; exited only by reset.
  - rf_wr_en = 0; imem_addr holds the PC of the halting instruction.
  - imem_valid is ignored.
- Reset asserted mid-instruction, including during WB: rf_wr_en drops immediately (asynchronously), no partial write-back, retired is not incremented.
- The rf_wr_en output is registered; there is no combinational path from imem_rdata to any output.

Decomposition:
- Shared package cpu_pkg holds:
  - the opcode constants: OPC_LOADI..OPC_OR, OPC_HALT;
  - the ALU_FWD/ADD/AND/OR encodings;
  - the state enum;
  - the instruction field bit positions.
- One sub-module, cpu_decoder: purely combinational, opcode to {alu_sel, sub_sel, imm_sel, legal, is_halt}. The FSM, PC, IR and counter stay in cpu_ctrl_fsm.

Test Plan:
- Reset, then imem_valid = 1 with imem_rdata = 32'h00_03_00_2A (loadi r3, 42):
  - DECODE: rf_in_addr = 3, imm_sel = 1, imm = 42, alu_sel = 0.
  - WB: rf_wr_en = 1 for exactly 1 cycle.
  - After WB: PC = 1, retired = 1.
- Fetch 32'h03_05_01_02 (sub r5, r1, r2):
  - rf_out1_addr = 1, rf_out2_addr = 2, rf_in_addr = 5, alu_sel = 1, sub_sel = 1, imm_sel = 0.
  - The address outputs do not change while rf_wr_en = 1.
- Hold imem_valid = 0 for 5 cycles, then 1:
  - FSM stays in FETCH with imem_addr constant and rf_wr_en = 0.
  - The instruction completes 4 cycles after imem_valid rises.
- Opcode 8'hFF at PC = 7 → halted = 1, illegal = 0, imem_addr stays 7, no rf_wr_en. Opcode 8'h09 → halted = 1, illegal = 1.
- Preload PC = 255 via RESET_PC = 255 and execute one add → PC wraps to 0. Assert reset asynchronously mid-WB → rf_wr_en falls before the next clk edge, retired unchanged, PC = RESET_PC.
